// File: rtl/decode_queue.sv
// decode_queue: RV32IMA decoder feeding a DEPTH-entry FIFO between fetch and execute.
// Define DECODE_ILLEGAL_CHECK_EN to build the strict illegal-instruction check.
module decode_queue #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [2:0]       out_fmt,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [31:0]      out_imm,
  output logic             out_writes_reg,
  output logic             out_is_load,
  output logic             out_is_store,
  output logic             out_is_branch,
  output logic             out_illegal,
  output logic [PTR_W:0]   count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_AMO    = 7'b0101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        writes_reg;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        illegal;
  } entry_t;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       dec_illegal;
  entry_t     dec;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.opcode = opc;
    dec.funct3 = f3;
    dec.funct7 = f7;
    case (opc)
      OPC_OP, OPC_AMO:                                        dec.fmt = FMT_R;
      OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_FENCE, OPC_SYSTEM:   dec.fmt = FMT_I;
      OPC_STORE:                                              dec.fmt = FMT_S;
      OPC_BRANCH:                                             dec.fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                                     dec.fmt = FMT_U;
      OPC_JAL:                                                dec.fmt = FMT_J;
      default:                                                dec.fmt = FMT_NONE;
    endcase
    case (dec.fmt)
      FMT_R: begin
        dec.rd  = in_instr[11:7];
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
      end
      FMT_I: begin
        dec.rd  = in_instr[11:7];
        dec.rs1 = in_instr[19:15];
        dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      FMT_S: begin
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
        dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      FMT_B: begin
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
        dec.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      FMT_U: begin
        dec.rd  = in_instr[11:7];
        dec.imm = {in_instr[31:12], 12'b0};
      end
      FMT_J: begin
        dec.rd  = in_instr[11:7];
        dec.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      default: ;
    endcase
    // SYSTEM with funct3=0 covers ecall/ebreak/xret/wfi/sfence.vma: none write rd
    dec.illegal    = dec_illegal;
    dec.writes_reg = (dec.rd != 5'd0) && (opc != OPC_FENCE) &&
                     !((opc == OPC_SYSTEM) && (f3 == 3'b000)) && !dec_illegal;
    dec.is_load    = (opc == OPC_LOAD) && (f3 != 3'b011) && (f3[2:1] != 2'b11) && !dec_illegal;
    dec.is_store   = (opc == OPC_STORE) && !f3[2] && (f3 != 3'b011) && !dec_illegal;
    dec.is_branch  = (opc == OPC_BRANCH) && (f3[2:1] != 2'b01) && !dec_illegal;
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic legal;

  always_comb begin
    legal = 1'b0;
    case (opc)
      OPC_OP: legal = (f7 == 7'b0000000) || (f7 == 7'b0000001) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      OPC_AMO: begin
        if (f3 == 3'b010) begin
          case (in_instr[31:27])
            5'b00010: legal = (in_instr[24:20] == 5'd0);
            5'b00011, 5'b00001, 5'b00000, 5'b00100, 5'b01100,
            5'b01000, 5'b10000, 5'b10100, 5'b11000, 5'b11100: legal = 1'b1;
            default: legal = 1'b0;
          endcase
        end
      end
      OPC_JALR:   legal = (f3 == 3'b000);
      OPC_LOAD:   legal = (f3 != 3'b011) && (f3[2:1] != 2'b11);
      OPC_OPIMM: begin
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
      end
      OPC_FENCE:  legal = (f3[2:1] == 2'b00);
      OPC_SYSTEM: begin
        if (f3 == 3'b000)
          legal = (in_instr == 32'h0000_0073) || (in_instr == 32'h0010_0073) ||
                  (in_instr == 32'h1020_0073) || (in_instr == 32'h3020_0073) ||
                  (in_instr == 32'h1050_0073) ||
                  ((f7 == 7'b0001001) && (in_instr[11:7] == 5'd0));
        else
          legal = (f3 != 3'b100);
      end
      OPC_STORE:  legal = !f3[2] && (f3 != 3'b011);
      OPC_BRANCH: legal = (f3[2:1] != 2'b01);
      OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
      default:    legal = 1'b0;
    endcase
  end

  assign dec_illegal = ~legal;
`else
  assign dec_illegal = 1'b0;
`endif

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;
  entry_t           mem_q [DEPTH];
  entry_t           head;

  assign in_ready  = (count_q < (PTR_W+1)'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is not reset; occupancy alone qualifies it
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= dec;
  end

  assign head           = mem_q[rd_ptr_q];
  assign out_pc         = head.pc;
  assign out_fmt        = head.fmt;
  assign out_opcode     = head.opcode;
  assign out_funct3     = head.funct3;
  assign out_funct7     = head.funct7;
  assign out_rd         = head.rd;
  assign out_rs1        = head.rs1;
  assign out_rs2        = head.rs2;
  assign out_imm        = head.imm;
  assign out_writes_reg = head.writes_reg;
  assign out_is_load    = head.is_load;
  assign out_is_store   = head.is_store;
  assign out_is_branch  = head.is_branch;
  assign out_illegal    = head.illegal;
  assign count          = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: table vectors, handshake/flush/reset corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_decode_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_imm;
  logic [2:0]  out_fmt, out_funct3;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_writes_reg, out_is_load, out_is_store, out_is_branch, out_illegal;
  logic [2:0]  count;

  decode_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_fmt(out_fmt),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_writes_reg(out_writes_reg), .out_is_load(out_is_load), .out_is_store(out_is_store),
    .out_is_branch(out_is_branch), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [2:0]  f3;
    logic [6:0]  opcode;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic        wr, ld, st, br, ill;
  } rec_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        wr, ld, st, br, ill;
  } vec_t;

  rec_t        mq[$];
  vec_t        vt [12];
  logic [31:0] order_pc [4];
  int          total = 0;
  int          bad   = 0;
  bit          ill_on;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

`ifdef DECODE_ILLEGAL_CHECK_EN
  function automatic bit mm(input logic [31:0] ins, input logic [31:0] mask, input logic [31:0] match);
    return (ins & mask) == match;
  endfunction

  // Mask/match list of every RV32IMA + privileged encoding
  function automatic bit is_legal(input logic [31:0] ins);
    bit ok;
    ok = mm(ins, 32'h7F, 32'h37) | mm(ins, 32'h7F, 32'h17) | mm(ins, 32'h7F, 32'h6F);
    ok |= mm(ins, 32'h707F, 32'h67) | mm(ins, 32'h707F, 32'h63) | mm(ins, 32'h707F, 32'h1063) |
          mm(ins, 32'h707F, 32'h4063) | mm(ins, 32'h707F, 32'h5063) | mm(ins, 32'h707F, 32'h6063) |
          mm(ins, 32'h707F, 32'h7063);
    ok |= mm(ins, 32'h707F, 32'h03) | mm(ins, 32'h707F, 32'h1003) | mm(ins, 32'h707F, 32'h2003) |
          mm(ins, 32'h707F, 32'h4003) | mm(ins, 32'h707F, 32'h5003);
    ok |= mm(ins, 32'h707F, 32'h23) | mm(ins, 32'h707F, 32'h1023) | mm(ins, 32'h707F, 32'h2023);
    ok |= mm(ins, 32'h707F, 32'h13) | mm(ins, 32'h707F, 32'h2013) | mm(ins, 32'h707F, 32'h3013) |
          mm(ins, 32'h707F, 32'h4013) | mm(ins, 32'h707F, 32'h6013) | mm(ins, 32'h707F, 32'h7013);
    ok |= mm(ins, 32'hFE00707F, 32'h1013) | mm(ins, 32'hFE00707F, 32'h5013) |
          mm(ins, 32'hFE00707F, 32'h40005013);
    ok |= mm(ins, 32'hFE00707F, 32'h33) | mm(ins, 32'hFE00707F, 32'h40000033) |
          mm(ins, 32'hFE00707F, 32'h1033) | mm(ins, 32'hFE00707F, 32'h2033) |
          mm(ins, 32'hFE00707F, 32'h3033) | mm(ins, 32'hFE00707F, 32'h4033) |
          mm(ins, 32'hFE00707F, 32'h5033) | mm(ins, 32'hFE00707F, 32'h40005033) |
          mm(ins, 32'hFE00707F, 32'h6033) | mm(ins, 32'hFE00707F, 32'h7033) |
          mm(ins, 32'hFE00007F, 32'h02000033);
    ok |= mm(ins, 32'h707F, 32'h0F) | mm(ins, 32'h707F, 32'h100F);
    ok |= mm(ins, 32'hFFFFFFFF, 32'h73) | mm(ins, 32'hFFFFFFFF, 32'h00100073) |
          mm(ins, 32'hFFFFFFFF, 32'h10200073) | mm(ins, 32'hFFFFFFFF, 32'h30200073) |
          mm(ins, 32'hFFFFFFFF, 32'h10500073) | mm(ins, 32'hFE007FFF, 32'h12000073);
    ok |= mm(ins, 32'h707F, 32'h1073) | mm(ins, 32'h707F, 32'h2073) | mm(ins, 32'h707F, 32'h3073) |
          mm(ins, 32'h707F, 32'h5073) | mm(ins, 32'h707F, 32'h6073) | mm(ins, 32'h707F, 32'h7073);
    ok |= mm(ins, 32'hF9F0707F, 32'h1000202F) | mm(ins, 32'hF800707F, 32'h1800202F) |
          mm(ins, 32'hF800707F, 32'h0800202F) | mm(ins, 32'hF800707F, 32'h0000202F) |
          mm(ins, 32'hF800707F, 32'h2000202F) | mm(ins, 32'hF800707F, 32'h6000202F) |
          mm(ins, 32'hF800707F, 32'h4000202F) | mm(ins, 32'hF800707F, 32'h8000202F) |
          mm(ins, 32'hF800707F, 32'hA000202F) | mm(ins, 32'hF800707F, 32'hC000202F) |
          mm(ins, 32'hF800707F, 32'hE000202F);
    return ok;
  endfunction
`endif

  function automatic rec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    rec_t r;
    int   s;
    bit   has_rd, has_rs1, has_rs2, sys_priv;
    s        = int'(ins);
    r.pc     = pc;
    r.opcode = ins[6:0];
    r.f3     = ins[14:12];
    r.f7     = ins[31:25];
    case (ins[6:0])
      7'h33, 7'h2F:                      r.fmt = 3'd1;
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: r.fmt = 3'd2;
      7'h23:                             r.fmt = 3'd3;
      7'h63:                             r.fmt = 3'd4;
      7'h37, 7'h17:                      r.fmt = 3'd5;
      7'h6F:                             r.fmt = 3'd6;
      default:                           r.fmt = 3'd0;
    endcase
    has_rd  = r.fmt inside {3'd1, 3'd2, 3'd5, 3'd6};
    has_rs1 = r.fmt inside {3'd1, 3'd2, 3'd3, 3'd4};
    has_rs2 = r.fmt inside {3'd1, 3'd3, 3'd4};
    r.rd  = has_rd  ? ins[11:7]  : 5'd0;
    r.rs1 = has_rs1 ? ins[19:15] : 5'd0;
    r.rs2 = has_rs2 ? ins[24:20] : 5'd0;
    case (r.fmt)
      3'd2:    r.imm = 32'(s >>> 20);
      3'd3:    r.imm = 32'((s >>> 25) * 32 + int'(ins[11:7]));
      3'd4:    r.imm = 32'((s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
      3'd5:    r.imm = ins & 32'hFFFFF000;
      3'd6:    r.imm = 32'((s >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
      default: r.imm = 32'd0;
    endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
    r.ill = !is_legal(ins);
`else
    r.ill = 1'b0;
`endif
    sys_priv = (ins[6:0] == 7'h73) && (ins[14:12] == 3'd0);
    r.wr = (r.rd != 5'd0) && (ins[6:0] != 7'h0F) && !sys_priv && !r.ill;
    r.ld = (ins[6:0] == 7'h03) && (ins[14:12] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !r.ill;
    r.st = (ins[6:0] == 7'h23) && (ins[14:12] inside {3'd0, 3'd1, 3'd2}) && !r.ill;
    r.br = (ins[6:0] == 7'h63) && !(ins[14:12] inside {3'd2, 3'd3}) && !r.ill;
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom();
    case ($urandom_range(0, 12))
      0: op = 7'h33;  1: op = 7'h2F;  2: op = 7'h67;  3: op = 7'h03;
      4: op = 7'h13;  5: op = 7'h0F;  6: op = 7'h73;  7: op = 7'h23;
      8: op = 7'h63;  9: op = 7'h37;  10: op = 7'h17; 11: op = 7'h6F;
      default: op = r[6:0];
    endcase
    if ($urandom_range(0, 3) == 0) r[31:25] = 7'h00;
    return {r[31:7], op};
  endfunction

  task automatic check_state(input string tag);
    rec_t h;
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() < DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      h = mq[0];
      chk({tag, ".pc"}, out_pc, h.pc);
      chk({tag, ".fmt"}, 32'(out_fmt), 32'(h.fmt));
      chk({tag, ".opcode"}, 32'(out_opcode), 32'(h.opcode));
      chk({tag, ".funct3"}, 32'(out_funct3), 32'(h.f3));
      chk({tag, ".funct7"}, 32'(out_funct7), 32'(h.f7));
      chk({tag, ".rd"}, 32'(out_rd), 32'(h.rd));
      chk({tag, ".rs1"}, 32'(out_rs1), 32'(h.rs1));
      chk({tag, ".rs2"}, 32'(out_rs2), 32'(h.rs2));
      chk({tag, ".imm"}, out_imm, h.imm);
      chk({tag, ".writes_reg"}, 32'(out_writes_reg), 32'(h.wr));
      chk({tag, ".is_load"}, 32'(out_is_load), 32'(h.ld));
      chk({tag, ".is_store"}, 32'(out_is_store), 32'(h.st));
      chk({tag, ".is_branch"}, 32'(out_is_branch), 32'(h.br));
      chk({tag, ".illegal"}, 32'(out_illegal), 32'(h.ill));
    end
  endtask

  // Called at a negedge: drive, let one posedge happen, update the model, check at next negedge
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl, input string tag);
    bit push, pop;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    push = v && (mq.size() < DEPTH);
    pop  = rdy && (mq.size() != 0);
    @(posedge clk);
    if (!rstn || fl) begin
      mq.delete();
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(ref_decode(ins, pc));
    end
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
`ifdef DECODE_ILLEGAL_CHECK_EN
    ill_on = 1'b1;
`else
    ill_on = 1'b0;
`endif
    //          instr          fmt   rd     rs1    rs2    imm            wr    ld    st    br    ill
    vt[0]  = '{32'hFFF00093, 3'd2, 5'd1,  5'd0,  5'd0,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{32'hFE208EE3, 3'd4, 5'd0,  5'd1,  5'd2,  32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{32'h123452B7, 3'd5, 5'd5,  5'd0,  5'd0,  32'h12345000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{32'h0020A423, 3'd3, 5'd0,  5'd1,  5'd2,  32'h00000008, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{32'hFF812183, 3'd2, 5'd3,  5'd2,  5'd0,  32'hFFFFFFF8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{32'h00C58533, 3'd1, 5'd10, 5'd11, 5'd12, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{32'h001000EF, 3'd6, 5'd1,  5'd0,  5'd0,  32'h00000800, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{32'h00000073, 3'd2, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{32'h300312F3, 3'd2, 5'd5,  5'd6,  5'd0,  32'h00000300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{32'h00000000, 3'd0, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[10] = '{32'h00000033, 3'd1, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{32'hFFFFF397, 3'd5, 5'd7,  5'd0,  5'd0,  32'hFFFFF000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    order_pc = '{32'h204, 32'h208, 32'h20C, 32'h300};

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_instr = '0;
    @(negedge clk);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "rst0");
    cycle(1'b1, 32'h13, 32'h0, 1'b0, 1'b0, "rst1");
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    rstn = 1'b1;

    // Table vectors: each pushed into an empty queue, checked next cycle, then popped
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, vt[i].instr, 32'h100 + 32'(i * 4), 1'b0, 1'b0, "vec.push");
      $display("vec %0d instr=%h pc=%h fmt=%0d rd=%0d imm=%h", i, vt[i].instr, out_pc, out_fmt, out_rd, out_imm);
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d.pc", i), out_pc, 32'h100 + 32'(i * 4));
      chk($sformatf("vec%0d.fmt", i), 32'(out_fmt), 32'(vt[i].fmt));
      chk($sformatf("vec%0d.rd", i), 32'(out_rd), 32'(vt[i].rd));
      chk($sformatf("vec%0d.rs1", i), 32'(out_rs1), 32'(vt[i].rs1));
      chk($sformatf("vec%0d.rs2", i), 32'(out_rs2), 32'(vt[i].rs2));
      chk($sformatf("vec%0d.imm", i), out_imm, vt[i].imm);
      chk($sformatf("vec%0d.writes_reg", i), 32'(out_writes_reg), 32'(vt[i].wr));
      chk($sformatf("vec%0d.is_load", i), 32'(out_is_load), 32'(vt[i].ld));
      chk($sformatf("vec%0d.is_store", i), 32'(out_is_store), 32'(vt[i].st));
      chk($sformatf("vec%0d.is_branch", i), 32'(out_is_branch), 32'(vt[i].br));
      chk($sformatf("vec%0d.illegal", i), 32'(out_illegal), 32'(vt[i].ill & ill_on));
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "vec.pop");
    end

    // Fill to DEPTH, hold a 5th offer, pop one, then drain across the pointer wrap
    for (int k = 0; k < 4; k++) cycle(1'b1, rand_instr(), 32'h200 + 32'(k * 4), 1'b0, 1'b0, "fill");
    chk("full.count", 32'(count), 32'd4);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 32'h00500293, 32'h300, 1'b0, 1'b0, "hold");
    chk("hold.count", 32'(count), 32'd4);
    chk("hold.head_pc", out_pc, 32'h200);
    cycle(1'b1, 32'h00500293, 32'h300, 1'b1, 1'b0, "pop1");
    chk("pop1.in_ready", 32'(in_ready), 32'd1);
    chk("pop1.count", 32'(count), 32'd3);
    cycle(1'b1, 32'h00500293, 32'h300, 1'b0, 1'b0, "push5");
    chk("push5.count", 32'(count), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("order%0d.pc", k), out_pc, order_pc[k]);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain");
    end
    chk("drain.out_valid", 32'(out_valid), 32'd0);

    // Push+pop at count=2, then flush with a same-cycle push
    cycle(1'b1, rand_instr(), 32'h400, 1'b0, 1'b0, "pp");
    cycle(1'b1, rand_instr(), 32'h404, 1'b0, 1'b0, "pp");
    chk("pp.count_before", 32'(count), 32'd2);
    cycle(1'b1, rand_instr(), 32'h408, 1'b1, 1'b0, "pp.both");
    chk("pp.count_after", 32'(count), 32'd2);
    chk("pp.head_pc", out_pc, 32'h404);
    cycle(1'b1, rand_instr(), 32'h40C, 1'b1, 1'b1, "flush");
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "flush.idle");
    chk("flush.dropped", 32'(out_valid), 32'd0);

    // Reset mid-stream behaves like flush
    cycle(1'b1, rand_instr(), 32'h500, 1'b0, 1'b0, "mid");
    cycle(1'b1, rand_instr(), 32'h504, 1'b0, 1'b0, "mid");
    rstn = 1'b0;
    cycle(1'b1, rand_instr(), 32'h508, 1'b1, 1'b0, "mid.rst");
    rstn = 1'b1;
    chk("midrst.count", 32'(count), 32'd0);
    chk("midrst.out_valid", 32'(out_valid), 32'd0);

    // Randomized traffic with phases of slow and fast drain
    for (int n = 0; n < 800; n++) begin
      logic       v, rdy, fl;
      v    = ($urandom_range(0, 3) != 0);
      rdy  = ((n % 200) < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 39) == 0);
      rstn = ($urandom_range(0, 149) != 0);
      cycle(v, rand_instr(), $urandom() & 32'hFFFF_FFFC, rdy, fl, "rand");
    end
    rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
